// File: rtl/branch_resolver.sv
// EX-stage branch resolver: carries BTB predictions down IF/ID and ID/EX, compares
// them against the actual outcome, issues redirects and drives the BTB update port.
module branch_resolver #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             stall,
    input  logic             flush_ext,
    input  logic [31:0]      PC_IF,
    input  logic             predict_IF,
    input  logic [31:0]      preaddr,
    input  logic             is_branch_EX,
    input  logic             taken_EX,
    input  logic [31:0]      target_EX,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             branch_jump,
    output logic [31:0]      PC_happen,
    output logic [31:0]      PC_to,
    output logic             predict_EX,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispredict
);

    logic             ifid_v_q, ifid_v_d;
    logic [31:0]      ifid_pc_q, ifid_pc_d;
    logic             ifid_pt_q, ifid_pt_d;
    logic [31:0]      ifid_ptgt_q, ifid_ptgt_d;
    logic             idex_v_q, idex_v_d;
    logic [31:0]      idex_pc_q, idex_pc_d;
    logic             idex_pt_q, idex_pt_d;
    logic [31:0]      idex_ptgt_q, idex_ptgt_d;

    logic             branch_jump_q, branch_jump_d;
    logic [31:0]      pc_happen_q, pc_happen_d;
    logic [31:0]      pc_to_q, pc_to_d;
    logic             predict_ex_q, predict_ex_d;
    logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0] cnt_mispredict_q, cnt_mispredict_d;

    logic             fire;
    logic             update;
    logic [31:0]      fall;

    // Resolution: flush_ext and stall both mask the compare entirely.
    always_comb begin
        fire        = idex_v_q & ~stall & ~flush_ext;
        fall        = idex_pc_q + 32'd4;
        redirect    = 1'b0;
        redirect_pc = '0;
        if (fire) begin
            if (is_branch_EX && taken_EX && (!idex_pt_q || (idex_ptgt_q != target_EX))) begin
                redirect    = 1'b1;
                redirect_pc = target_EX;
            end else if (is_branch_EX && !taken_EX && idex_pt_q) begin
                redirect    = 1'b1;
                redirect_pc = fall;
            end else if (!is_branch_EX && idex_pt_q) begin
                redirect    = 1'b1;
                redirect_pc = fall;
            end
        end
        update = fire & is_branch_EX;
    end

    always_comb begin
        ifid_v_d    = ifid_v_q;
        ifid_pc_d   = ifid_pc_q;
        ifid_pt_d   = ifid_pt_q;
        ifid_ptgt_d = ifid_ptgt_q;
        idex_v_d    = idex_v_q;
        idex_pc_d   = idex_pc_q;
        idex_pt_d   = idex_pt_q;
        idex_ptgt_d = idex_ptgt_q;
        if (flush_ext || redirect) begin
            ifid_v_d = 1'b0;
            idex_v_d = 1'b0;
        end else if (!stall) begin
            ifid_v_d    = 1'b1;
            ifid_pc_d   = PC_IF;
            ifid_pt_d   = predict_IF;
            ifid_ptgt_d = preaddr;
            idex_v_d    = ifid_v_q;
            idex_pc_d   = ifid_pc_q;
            idex_pt_d   = ifid_pt_q;
            idex_ptgt_d = ifid_ptgt_q;
        end
    end

    // BTB update fields hold between strobes; counters saturate at all-ones.
    always_comb begin
        branch_jump_d    = update;
        pc_happen_d      = pc_happen_q;
        pc_to_d          = pc_to_q;
        predict_ex_d     = predict_ex_q;
        cnt_branch_d     = cnt_branch_q;
        cnt_mispredict_d = cnt_mispredict_q;
        if (update) begin
            pc_happen_d  = idex_pc_q;
            pc_to_d      = target_EX;
            predict_ex_d = ~taken_EX;
            if (cnt_branch_q != '1)
                cnt_branch_d = cnt_branch_q + CNT_W'(1);
        end
        if (redirect && (cnt_mispredict_q != '1))
            cnt_mispredict_d = cnt_mispredict_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ifid_v_q         <= 1'b0;
            ifid_pc_q        <= '0;
            ifid_pt_q        <= 1'b0;
            ifid_ptgt_q      <= '0;
            idex_v_q         <= 1'b0;
            idex_pc_q        <= '0;
            idex_pt_q        <= 1'b0;
            idex_ptgt_q      <= '0;
            branch_jump_q    <= 1'b0;
            pc_happen_q      <= '0;
            pc_to_q          <= '0;
            predict_ex_q     <= 1'b0;
            cnt_branch_q     <= '0;
            cnt_mispredict_q <= '0;
        end else begin
            ifid_v_q         <= ifid_v_d;
            ifid_pc_q        <= ifid_pc_d;
            ifid_pt_q        <= ifid_pt_d;
            ifid_ptgt_q      <= ifid_ptgt_d;
            idex_v_q         <= idex_v_d;
            idex_pc_q        <= idex_pc_d;
            idex_pt_q        <= idex_pt_d;
            idex_ptgt_q      <= idex_ptgt_d;
            branch_jump_q    <= branch_jump_d;
            pc_happen_q      <= pc_happen_d;
            pc_to_q          <= pc_to_d;
            predict_ex_q     <= predict_ex_d;
            cnt_branch_q     <= cnt_branch_d;
            cnt_mispredict_q <= cnt_mispredict_d;
        end
    end

    assign branch_jump    = branch_jump_q;
    assign PC_happen      = pc_happen_q;
    assign PC_to          = pc_to_q;
    assign predict_EX     = predict_ex_q;
    assign cnt_branch     = cnt_branch_q;
    assign cnt_mispredict = cnt_mispredict_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, stall/flush/reset sequences and
// randomized traffic against a queue-based model; a CNT_W=2 copy checks saturation.
module tb_branch_resolver;

    logic        CLK, RSTn, stall, flush_ext, predict_IF, is_branch_EX, taken_EX;
    logic [31:0] PC_IF, preaddr, target_EX;
    logic        redirect, branch_jump, predict_EX;
    logic [31:0] redirect_pc, PC_happen, PC_to, cnt_branch, cnt_mispredict;
    logic        d2_redirect, d2_branch_jump, d2_predict_EX;
    logic [31:0] d2_redirect_pc, d2_PC_happen, d2_PC_to;
    logic [1:0]  d2_cnt_branch, d2_cnt_mispredict;

    int checks = 0;
    int failures = 0;

    branch_resolver #(.CNT_W(32)) dut (
        .CLK(CLK), .RSTn(RSTn), .stall(stall), .flush_ext(flush_ext), .PC_IF(PC_IF),
        .predict_IF(predict_IF), .preaddr(preaddr), .is_branch_EX(is_branch_EX),
        .taken_EX(taken_EX), .target_EX(target_EX), .redirect(redirect),
        .redirect_pc(redirect_pc), .branch_jump(branch_jump), .PC_happen(PC_happen),
        .PC_to(PC_to), .predict_EX(predict_EX), .cnt_branch(cnt_branch),
        .cnt_mispredict(cnt_mispredict)
    );

    branch_resolver #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RSTn(RSTn), .stall(stall), .flush_ext(flush_ext), .PC_IF(PC_IF),
        .predict_IF(predict_IF), .preaddr(preaddr), .is_branch_EX(is_branch_EX),
        .taken_EX(taken_EX), .target_EX(target_EX), .redirect(d2_redirect),
        .redirect_pc(d2_redirect_pc), .branch_jump(d2_branch_jump), .PC_happen(d2_PC_happen),
        .PC_to(d2_PC_to), .predict_EX(d2_predict_EX), .cnt_branch(d2_cnt_branch),
        .cnt_mispredict(d2_cnt_mispredict)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: the in-flight instructions, youngest first; an instruction reaches EX
    // once two later edges have carried it, and a flush simply forgets them all.
    typedef struct packed {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
    } fetch_t;
    fetch_t pipe[$];

    logic            m_bj, m_pex;
    logic [31:0]     m_ph, m_pto;
    longint unsigned m_cb, m_cm;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        ib;
        logic        tk;
        logic [31:0] tgt;
        logic        er;
        logic [31:0] erpc;
        logic        ebj;
        logic        epex;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic longint unsigned sat2(input longint unsigned v);
        return (v > 3) ? 64'd3 : v;
    endfunction

    task automatic model_reset();
        pipe.delete();
        m_bj = 1'b0; m_pex = 1'b0; m_ph = '0; m_pto = '0; m_cb = 0; m_cm = 0;
    endtask

    task automatic model_comb(output logic r, output logic [31:0] rpc);
        fetch_t e;
        r = 1'b0;
        rpc = '0;
        if (RSTn && pipe.size() == 2 && !stall && !flush_ext) begin
            e = pipe[1];
            if (is_branch_EX && taken_EX && (!e.pt || e.ptgt != target_EX)) begin
                r = 1'b1; rpc = target_EX;
            end else if (e.pt && !(is_branch_EX && taken_EX)) begin
                r = 1'b1; rpc = e.pc + 32'd4;
            end
        end
    endtask

    task automatic model_edge(input logic r);
        fetch_t nf;
        if (!RSTn) begin
            model_reset();
            return;
        end
        m_bj = 1'b0;
        if (pipe.size() == 2 && !stall && !flush_ext && is_branch_EX) begin
            m_bj = 1'b1; m_ph = pipe[1].pc; m_pto = target_EX; m_pex = !taken_EX;
            m_cb++;
        end
        if (r) m_cm++;
        if (flush_ext || r) pipe.delete();
        else if (!stall) begin
            nf.pc = PC_IF; nf.pt = predict_IF; nf.ptgt = preaddr;
            pipe.push_front(nf);
            if (pipe.size() > 2) void'(pipe.pop_back());
        end
    endtask

    // Called at posedge+1 with inputs set; returns the combinational outputs seen mid-cycle.
    task automatic tick(output logic r_s, output logic [31:0] rpc_s);
        logic er;
        logic [31:0] erpc;
        model_comb(er, erpc);
        @(negedge CLK);
        r_s = redirect;
        rpc_s = redirect_pc;
        chk("redirect", 64'(redirect), 64'(er));
        chk("redirect_pc", 64'(redirect_pc), 64'(erpc));
        @(posedge CLK);
        model_edge(er);
        #1;
        chk("branch_jump", 64'(branch_jump), 64'(m_bj));
        chk("PC_happen", 64'(PC_happen), 64'(m_ph));
        chk("PC_to", 64'(PC_to), 64'(m_pto));
        chk("predict_EX", 64'(predict_EX), 64'(m_pex));
        chk("cnt_branch", 64'(cnt_branch), 64'(m_cb));
        chk("cnt_mispredict", 64'(cnt_mispredict), 64'(m_cm));
        chk("sat_cnt_branch", 64'(d2_cnt_branch), sat2(m_cb));
        chk("sat_cnt_mispredict", 64'(d2_cnt_mispredict), sat2(m_cm));
    endtask

    task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        PC_IF = pc; predict_IF = pt; preaddr = ptgt;
    endtask

    task automatic set_ex(input logic ib, input logic tk, input logic [31:0] tgt);
        is_branch_EX = ib; taken_EX = tk; target_EX = tgt;
    endtask

    initial begin
        logic r;
        logic [31:0] rpc;
        int nred, nbj;

        vecs[0] = '{32'h100, 1, 32'h200, 1, 1, 32'h200, 0, 32'h0, 1, 0};
        vecs[1] = '{32'h100, 1, 32'h200, 1, 0, 32'h200, 1, 32'h104, 1, 1};
        vecs[2] = '{32'h40, 0, 32'h0, 1, 1, 32'h80, 1, 32'h80, 1, 0};
        vecs[3] = '{32'h40, 1, 32'h80, 1, 1, 32'h90, 1, 32'h90, 1, 0};
        vecs[4] = '{32'hFFFFFFFC, 1, 32'h1234, 0, 0, 32'h0, 1, 32'h0, 0, 0};
        vecs[5] = '{32'h300, 0, 32'h0, 1, 0, 32'h500, 0, 32'h0, 1, 1};
        vecs[6] = '{32'h500, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0};

        RSTn = 1'b0; stall = 1'b0; flush_ext = 1'b0;
        fetch(32'h0, 0, 32'h0);
        set_ex(0, 0, 32'h0);
        model_reset();
        #12;
        chk("rst_redirect", 64'(redirect), 64'd0);
        chk("rst_branch_jump", 64'(branch_jump), 64'd0);
        chk("rst_PC_happen", 64'(PC_happen), 64'd0);
        chk("rst_cnt_mispredict", 64'(cnt_mispredict), 64'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;

        foreach (vecs[i]) begin
            fetch(vecs[i].pc, vecs[i].pt, vecs[i].ptgt);
            tick(r, rpc);
            fetch(32'h1000, 0, 32'h0);
            tick(r, rpc);
            set_ex(vecs[i].ib, vecs[i].tk, vecs[i].tgt);
            tick(r, rpc);
            chk($sformatf("vec%0d_redirect", i), 64'(r), 64'(vecs[i].er));
            chk($sformatf("vec%0d_redirect_pc", i), 64'(rpc), 64'(vecs[i].erpc));
            chk($sformatf("vec%0d_branch_jump", i), 64'(branch_jump), 64'(vecs[i].ebj));
            if (vecs[i].ebj) begin
                chk($sformatf("vec%0d_PC_happen", i), 64'(PC_happen), 64'(vecs[i].pc));
                chk($sformatf("vec%0d_PC_to", i), 64'(PC_to), 64'(vecs[i].tgt));
                chk($sformatf("vec%0d_predict_EX", i), 64'(predict_EX), 64'(vecs[i].epex));
            end
            set_ex(0, 0, 32'h0);
            tick(r, rpc);
            if (vecs[i].er) chk($sformatf("vec%0d_post_flush", i), 64'(r), 64'd0);
        end
        chk("table_cnt_branch", 64'(cnt_branch), 64'd5);
        chk("table_cnt_mispredict", 64'(cnt_mispredict), 64'd4);

        // Mispredicting branch held in ID/EX by stall, then released.
        fetch(32'h100, 1, 32'h200);
        tick(r, rpc);
        fetch(32'h1000, 0, 32'h0);
        tick(r, rpc);
        set_ex(1, 0, 32'h200);
        stall = 1'b1;
        nred = 0; nbj = 0;
        for (int k = 0; k < 3; k++) begin
            tick(r, rpc);
            nred += int'(r);
            nbj += int'(branch_jump);
        end
        chk("stall_no_redirect", 64'(nred), 64'd0);
        stall = 1'b0;
        tick(r, rpc);
        nred += int'(r);
        nbj += int'(branch_jump);
        set_ex(0, 0, 32'h0);
        tick(r, rpc);
        nred += int'(r);
        nbj += int'(branch_jump);
        chk("stall_redirects", 64'(nred), 64'd1);
        chk("stall_bj_pulses", 64'(nbj), 64'd1);
        chk("sat_after_5", 64'(d2_cnt_mispredict), 64'd3);

        // Same branch killed by flush_ext.
        fetch(32'h100, 1, 32'h200);
        tick(r, rpc);
        fetch(32'h1000, 0, 32'h0);
        tick(r, rpc);
        set_ex(1, 0, 32'h200);
        flush_ext = 1'b1;
        tick(r, rpc);
        chk("flush_redirect", 64'(r), 64'd0);
        chk("flush_bj", 64'(branch_jump), 64'd0);
        flush_ext = 1'b0;
        tick(r, rpc);
        chk("flush_slots_cleared", 64'(r), 64'd0);
        set_ex(0, 0, 32'h0);

        // Reset arriving mid-stall with a mispredicting branch waiting in ID/EX.
        fetch(32'h100, 1, 32'h200);
        tick(r, rpc);
        fetch(32'h1000, 0, 32'h0);
        tick(r, rpc);
        set_ex(1, 0, 32'h200);
        stall = 1'b1;
        tick(r, rpc);
        #2;
        RSTn = 1'b0;
        model_reset();
        #1;
        chk("async_rst_redirect", 64'(redirect), 64'd0);
        chk("async_rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("async_rst_cnt_branch", 64'(cnt_branch), 64'd0);
        chk("async_rst_PC_to", 64'(PC_to), 64'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        stall = 1'b0;
        fetch(32'h100, 1, 32'h200);
        tick(r, rpc);
        chk("post_rst_edge1", 64'(r), 64'd0);
        tick(r, rpc);
        chk("post_rst_edge2", 64'(r), 64'd0);
        tick(r, rpc);
        chk("post_rst_first_resolve", 64'(r), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] tsel[4];
            tsel[0] = 32'h40; tsel[1] = 32'h80; tsel[2] = 32'h90; tsel[3] = 32'hFFFFFFFC;
            stall = ($urandom_range(0, 7) == 0);
            flush_ext = ($urandom_range(0, 24) == 0);
            fetch(tsel[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), tsel[$urandom_range(0, 2)]);
            set_ex(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), tsel[$urandom_range(0, 2)]);
            tick(r, rpc);
        end
        stall = 1'b0; flush_ext = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- EX-stage counterpart of the IF-stage branch target buffer.
- Carries each fetched instruction's prediction (predict_IF, preaddr) through IF/ID and ID/EX and compares it with the actual branch outcome in EX.
- On a mispredict it issues a same-cycle fetch redirect and pipeline flush.
- Drives the BTB update interface (branch_jump, PC_happen, PC_to, predict_EX) one cycle later, and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of the cnt_branch and cnt_mispredict counters

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
stall  in  1  freeze IF/ID and ID/EX prediction slots; suppresses resolution
flush_ext  in  1  external flush (exception); invalidates both slots
PC_IF  in  32  PC of the instruction being fetched
predict_IF  in  1  BTB predicts taken for PC_IF
preaddr  in  32  BTB predicted target
is_branch_EX  in  1  instruction in EX is a branch or jump
taken_EX  in  1  actual direction of the EX instruction
target_EX  in  32  actual target of the EX instruction
redirect  out  1  mispredict: refetch from redirect_pc; flush IF/ID and ID/EX
redirect_pc  out  32  correct fetch address
branch_jump  out  1  BTB write strobe (registered)
PC_happen  out  32  PC of the resolved branch (registered)
PC_to  out  32  actual target (registered)
predict_EX  out  1  1 = resolved not-taken (BTB decrements), 0 = taken (increments)
cnt_branch  out  CNT_W  resolved branches
cnt_mispredict  out  CNT_W  redirects issued

Behaviour:
- Each slot (IF/ID, ID/EX) holds {v, pc[31:0], pt, ptgt[31:0]}.
- Every edge with !stall: IF/ID <= {1, PC_IF, predict_IF, preaddr}; ID/EX <= IF/ID.
- Update priority at each edge: RSTn low > flush_ext > redirect > stall > advance.
  - flush_ext or redirect: both v bits cleared; the capture of PC_IF that cycle is discarded.
  - stall: both slots hold.
- Resolution is combinational and fires when ID/EX.v & !stall. Let fall = ID/EX.pc + 32'd4 (wraps modulo 2^32; no delay slot modelled).
  - is_branch_EX & taken_EX & (!pt | ptgt != target_EX) -> redirect=1, redirect_pc=target_EX.
  - is_branch_EX & !taken_EX & pt -> redirect=1, redirect_pc=fall.
  - !is_branch_EX & pt (BTB alias) -> redirect=1, redirect_pc=fall; no BTB update.
  - Otherwise redirect=0, redirect_pc=32'd0.
- redirect is forced to 0 when ID/EX.v=0, when stall=1, and while flush_ext=1 (flush_ext wins).
- BTB update:
  - Registered on the edge where resolution fires with is_branch_EX=1 (flush_ext low): next cycle branch_jump=1 for exactly one cycle, PC_happen=ID/EX.pc, PC_to=target_EX, predict_EX=!taken_EX.
  - Otherwise branch_jump=0; PC_happen, PC_to and predict_EX hold their last values.
- Counters, on the same edge:
  - cnt_branch+1 per resolved branch.
  - cnt_mispredict+1 per redirect, alias case included.
  - Both saturate at all-ones (no wrap).
- Reset (async, immediate): both v bits=0, all slot fields=0, branch_jump=0, PC_happen=0, PC_to=0, predict_EX=0, both counters=0.
  - Combinational outputs follow immediately: redirect=0, redirect_pc=0.
  - Reset asserted mid-stall or mid-redirect discards all in-flight state; the first resolution can occur no earlier than 2 edges after release.
- Latency:
  - Instruction fetched at edge N is resolved in the cycle after edge N+2, given no stall.
  - Redirect reaches fetch the same cycle; the BTB update lands one cycle after.

Test Plan:
1. Correct taken prediction: fetch PC 0x100, pt=1, ptgt 0x200; in EX is_branch=1, taken=1, target 0x200 -> redirect=0; next cycle branch_jump=1, PC_happen=0x100, PC_to=0x200, predict_EX=0; cnt_branch=1, cnt_mispredict=0.
2. Taken predicted, not taken: PC 0x100, pt=1, ptgt 0x200; taken=0 -> redirect=1, redirect_pc=0x104; both slots invalid next cycle; predict_EX=1; cnt_mispredict=1.
3. Not predicted, taken, then target mismatch: PC 0x40, pt=0; taken=1, target 0x80 -> redirect_pc=0x80. Then PC 0x40, pt=1, ptgt 0x80; target 0x90 -> redirect_pc=0x90; cnt_mispredict=2.
4. Alias and wrap: PC 0xFFFFFFFC, pt=1, is_branch=0 -> redirect=1, redirect_pc=0x00000000, branch_jump stays 0, cnt_branch unchanged.
5. Stall and flush: mispredicting branch sits in ID/EX with stall=1 for 3 cycles -> redirect=0 throughout; stall drop -> exactly one redirect and one branch_jump pulse. Same branch with flush_ext=1 -> no redirect, no update, slots cleared.
6. Reset and saturation: RSTn low mid-operation -> outputs zero asynchronously; with CNT_W=2, 5 mispredicts -> cnt_mispredict=3.
